// File: rtl/splitter4_ramped_pkg.sv
// Shared audio definitions for the four-way ramped splitter: widths, FSM
// states, unity gain and the gain clamp.
package splitter4_ramped_pkg;

  localparam int unsigned BITSIZE    = 16;
  localparam int unsigned GAINBITS   = 9;
  localparam int unsigned NCH        = 4;
  localparam int unsigned GAIN_UNITY = 1 << (GAINBITS - 1);

  typedef logic        [GAINBITS-1:0] gain_t;
  typedef logic signed [BITSIZE-1:0]  sample_t;

  typedef enum logic [2:0] {
    IDLE,
    CH0,
    CH1,
    CH2,
    CH3
  } state_e;

  // Targets above unity are limited to unity so the product can never overflow.
  function automatic gain_t gain_clamp(input gain_t g);
    return (g > gain_t'(GAIN_UNITY)) ? gain_t'(GAIN_UNITY) : g;
  endfunction

endpackage

// File: rtl/splitter4_ramped_if.sv
// Sample/gain input bundle and gained-output bundle of the splitter.
interface splitter4_ramped_if;
  import splitter4_ramped_pkg::*;

  logic    sample_valid;
  sample_t in;
  gain_t   gain1;
  gain_t   gain2;
  gain_t   gain3;
  gain_t   gain4;
  logic    busy;
  logic    out_valid;
  sample_t out1;
  sample_t out2;
  sample_t out3;
  sample_t out4;

  modport master (
    output sample_valid, in, gain1, gain2, gain3, gain4,
    input  busy, out_valid, out1, out2, out3, out4
  );

  modport slave (
    input  sample_valid, in, gain1, gain2, gain3, gain4,
    output busy, out_valid, out1, out2, out3, out4
  );

endinterface

// File: rtl/splitter4_ramped_gain_ramp.sv
// Per-channel de-zipper: the current gain moves one LSB toward the clamped
// target on each accepted sample.
module splitter4_ramped_gain_ramp
  import splitter4_ramped_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  step_en,
  input  gain_t target,
  output gain_t g_cur
);

  gain_t g_q;
  gain_t g_d;
  gain_t tgt_c;

  // Next gain: one step toward the clamped target when enabled.
  always_comb begin
    tgt_c = gain_clamp(target);
    g_d   = g_q;
    if (step_en) begin
      if (tgt_c > g_q) begin
        g_d = g_q + gain_t'(1);
      end else if (tgt_c < g_q) begin
        g_d = g_q - gain_t'(1);
      end
    end
  end

  // Gain register; reset mutes the channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= '0;
    end else begin
      g_q <= g_d;
    end
  end

  assign g_cur = g_q;

endmodule

// File: rtl/splitter4_ramped.sv
// Mono-to-four splitter with ramped per-channel gains and one shared
// multiplier walked across the channels by a small FSM.
module splitter4_ramped
  import splitter4_ramped_pkg::*;
(
  input logic clk,
  input logic rst,
  splitter4_ramped_if.slave bus
);

  localparam int unsigned PW = BITSIZE + GAINBITS + 1;

  state_e            state_q, state_d;
  sample_t           in_q, in_d;
  sample_t [2:0]     hold_q, hold_d;
  sample_t [NCH-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  gain_t             tgt   [NCH];
  gain_t             g_cur [NCH];
  gain_t             g_sel;
  logic              accept;

  logic signed [PW-1:0] mul_a;
  logic signed [PW-1:0] mul_b;
  logic signed [PW-1:0] prod;
  sample_t              res;
  logic                 unused_prod_bits;

  assign accept = (state_q == IDLE) && bus.sample_valid;

  assign tgt[0] = bus.gain1;
  assign tgt[1] = bus.gain2;
  assign tgt[2] = bus.gain3;
  assign tgt[3] = bus.gain4;

  for (genvar i = 0; i < NCH; i++) begin : g_ramp
    splitter4_ramped_gain_ramp u_ramp (
      .clk     (clk),
      .rst     (rst),
      .step_en (accept),
      .target  (tgt[i]),
      .g_cur   (g_cur[i])
    );
  end

  // Select the gain of the channel being multiplied this cycle.
  always_comb begin
    g_sel = '0;
    case (state_q)
      CH0:     g_sel = g_cur[0];
      CH1:     g_sel = g_cur[1];
      CH2:     g_sel = g_cur[2];
      CH3:     g_sel = g_cur[3];
      default: g_sel = '0;
    endcase
  end

  // Shared signed x unsigned multiply, then floor-shift by the unity exponent.
  always_comb begin
    mul_a            = PW'(in_q);
    mul_b            = $signed(PW'({1'b0, g_sel}));
    prod             = mul_a * mul_b;
    res              = prod[GAINBITS-1 +: BITSIZE];
    unused_prod_bits = ^{prod[PW-1 -: 2], prod[GAINBITS-2:0]};
  end

  // Next-state and output logic for the channel sequencer.
  // Channel 3 has no hold slot: its product goes straight into out_d[3]
  // on the same edge that transfers the other three holds.
  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          state_d = CH0;
          in_d    = bus.in;
        end
      end
      CH0: begin
        hold_d[0] = res;
        state_d   = CH1;
      end
      CH1: begin
        hold_d[1] = res;
        state_d   = CH2;
      end
      CH2: begin
        hold_d[2] = res;
        state_d   = CH3;
      end
      CH3: begin
        out_d       = {res, hold_q[2], hold_q[1], hold_q[0]};
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out1      = out_q[0];
  assign bus.out2      = out_q[1];
  assign bus.out3      = out_q[2];
  assign bus.out4      = out_q[3];

endmodule

// File: tb/tb_splitter4_ramped.sv
// Scoreboard bench for splitter4_ramped: the driver queues the expected
// outputs and cycle of each accepted sample, the monitor checks every
// out_valid against the queue head.
module tb_splitter4_ramped;
  import splitter4_ramped_pkg::*;

  typedef struct {
    logic [3:0][15:0] o;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];

  splitter4_ramped_if bus ();

  splitter4_ramped dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_valid_cycle", cyc, e.cyc);
        check("out1", $signed(bus.out1), $signed(e.o[0]));
        check("out2", $signed(bus.out2), $signed(e.o[1]));
        check("out3", $signed(bus.out3), $signed(e.o[2]));
        check("out4", $signed(bus.out4), $signed(e.o[3]));
      end
    end
  end

  // Issue one sample from a negedge; returns on the following negedge.
  task automatic send(input logic signed [15:0] x,
                      input logic [8:0] g1, input logic [8:0] g2,
                      input logic [8:0] g3, input logic [8:0] g4,
                      input logic signed [15:0] e1, input logic signed [15:0] e2,
                      input logic signed [15:0] e3, input logic signed [15:0] e4,
                      input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      check("busy_timeout", 32'(bus.busy), 0);
    end
    bus.in           = x;
    bus.gain1        = g1;
    bus.gain2        = g2;
    bus.gain3        = g3;
    bus.gain4        = g4;
    bus.sample_valid = 1'b1;
    if (push) begin
      e.o   = {e4, e3, e2, e1};
      e.cyc = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_same(input logic signed [15:0] x, input logic [8:0] g,
                           input logic signed [15:0] e);
    send(x, g, g, g, g, e, e, e, e, 1'b1);
  endtask

  initial begin
    int g;
    int n;
    bus.sample_valid = 1'b0;
    bus.in    = '0;
    bus.gain1 = '0;
    bus.gain2 = '0;
    bus.gain3 = '0;
    bus.gain4 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out1", $signed(bus.out1), 0);
    check("rst_out4", $signed(bus.out4), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fade-in from mute: sample k sees gain min(k,256); 1000*g/256 floored.
    for (int k = 1; k <= 260; k++) begin
      g = (k > 256) ? 256 : k;
      send_same(16'sd1000, 9'd256, 16'((1000 * g) / 256));
    end

    // Full-scale extremes at unity.
    send_same(-16'sd32768, 9'd256, -16'sd32768);
    send_same(16'sd32767, 9'd256, 16'sd32767);

    // Settle at 128 (128 steps down), then floor of a negative product.
    repeat (128) send_same(16'sd0, 9'd128, 16'sd0);
    send_same(-16'sd1, 9'd128, -16'sd1);
    send_same(16'sd1000, 9'd128, 16'sd500);

    // Independent channels; 300 clamps to unity.
    repeat (128) send(16'sd0, 9'd256, 9'd128, 9'd0, 9'd300, 0, 0, 0, 0, 1'b1);
    send(16'sd2048, 9'd256, 9'd128, 9'd0, 9'd300,
         16'sd2048, 16'sd1024, 16'sd0, 16'sd2048, 1'b1);

    // Resettle all at unity, then ramp down to 250.
    repeat (256) send_same(16'sd0, 9'd256, 16'sd0);
    send_same(16'sd256, 9'd250, 16'sd255);
    send_same(16'sd256, 9'd250, 16'sd254);
    send_same(16'sd256, 9'd250, 16'sd253);
    send_same(16'sd256, 9'd250, 16'sd252);
    send_same(16'sd256, 9'd250, 16'sd251);
    send_same(16'sd256, 9'd250, 16'sd250);
    send_same(16'sd256, 9'd250, 16'sd250);
    send_same(16'sd256, 9'd250, 16'sd250);

    // Strobe while busy is ignored: one result, gain stepped once (250->251).
    send_same(16'sd256, 9'd256, 16'sd251);
    check("busy_mid", 32'(bus.busy), 1);
    bus.in           = 16'sd1000;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_after", 32'(bus.busy), 0);
    check("sb_drained_strobe", sb.size(), 0);
    send_same(16'sd256, 9'd256, 16'sd252);

    // Reset mid-operation discards the sample and mutes the gains.
    send(16'sd1000, 9'd256, 9'd256, 9'd256, 9'd256, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out1", $signed(bus.out1), 0);
    check("mid_rst_out3", $signed(bus.out3), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_same(16'sd1000, 9'd256, 16'sd3);
    send_same(16'sd1000, 9'd256, 16'sd7);

    // Drain the scoreboard with a bounded wait.
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
